// File: rtl/keypad_scan_entry.sv
// 4x4 hex keypad scanner with whole-round debounce and a 16-bit hex entry shift register.
// Latency: DEBOUNCE*4*SCAN_DIV+1 clk from a clean press to key_valid; no backpressure, key_valid is a pulse.
module keypad_scan_entry #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  input  logic        clear,
  output logic [3:0]  col_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] entry,
  output logic [2:0]  digit_count,
  output logic        key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    PRESSED    = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic             sample;
  logic             round_done;

  assign sample     = (div == DIV_LAST);
  assign round_done = sample && (col == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      col <= 2'd0;
    end else if (sample) begin
      div <= '0;
      col <= col + 2'd1;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Hits in the current column: 0, 1, or 2 meaning "two or more".
  logic [1:0] col_hits;
  logic [1:0] col_row;

  always_comb begin
    col_hits = 2'd0;
    col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) begin
        col_row = 2'(r);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
  end

  logic [1:0] acc_hits;
  logic [3:0] acc_code;
  logic [2:0] hit_sum;
  logic [1:0] merged_hits;
  logic [3:0] merged_code;
  logic       round_one;
  logic [3:0] round_code;

  always_comb begin
    hit_sum     = {1'b0, acc_hits} + {1'b0, col_hits};
    merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    merged_code = (col_hits != 2'd0) ? {col_row, col} : acc_code;
    round_one   = round_done && (merged_hits == 2'd1);
    round_code  = merged_code;
  end

  always_ff @(posedge clk) begin
    if (rst || round_done) begin
      acc_hits <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      acc_hits <= merged_hits;
      acc_code <= merged_code;
    end
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       cand, cand_nxt;
  logic             accept;
  logic [3:0]       accept_code;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cand_nxt    = cand;
    accept      = 1'b0;
    accept_code = cand;
    if (round_done) begin
      unique case (state)
        IDLE: begin
          if (round_one) begin
            cand_nxt = round_code;
            cnt_nxt  = CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state_nxt   = PRESSED;
              accept      = 1'b1;
              accept_code = round_code;
            end else begin
              state_nxt = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (!round_one) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (round_code != cand) begin
            cand_nxt = round_code;
            cnt_nxt  = CNT_W'(1);
          end else begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state_nxt = PRESSED;
              accept    = 1'b1;
            end
          end
        end
        PRESSED: begin
          // Any single key keeps the press alive; only a clean NONE starts release.
          if (!round_one) begin
            if (DEBOUNCE == 1) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else begin
              state_nxt = RELEASE_DB;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        RELEASE_DB: begin
          if (round_one) begin
            state_nxt = PRESSED;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    col_n    = ~(4'b0001 << col);
    key_down = (state == PRESSED) || (state == RELEASE_DB);
  end

  // clear only owns entry/digit_count; the event itself still goes out.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
      entry       <= 16'd0;
      digit_count <= 3'd0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= accept_code;
      if (clear) begin
        entry       <= 16'd0;
        digit_count <= 3'd0;
      end else if (accept) begin
        entry <= {entry[11:0], accept_code};
        if (digit_count != 3'd4) digit_count <= digit_count + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Directed bench for keypad_scan_entry with SCAN_DIV=4, DEBOUNCE=2 and a behavioural 4x4 key matrix.
module tb_keypad_scan_entry;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int ROUND    = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  row_n;
  logic        clear;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic        key_down;

  logic [15:0] keys;   // bit 4*row+col = key pressed

  int errors = 0;
  int checks = 0;
  int cyc;
  int pulses;
  int first_pulse;

  keypad_scan_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .clear(clear), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .entry(entry),
    .digit_count(digit_count), .key_down(key_down)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (|(keys[4*r +: 4] & ~col_n)) row_n[r] = 1'b0;
    end
  end

  typedef struct {
    logic [15:0] keys;
    int          rounds;
    logic        clr;
    int          pulses;
    logic [3:0]  code;
    logic [15:0] ent;
    logic [2:0]  cnt;
    logic        down;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (key_valid === 1'b1) begin
      pulses++;
      if (first_pulse == 0) first_pulse = cyc;
    end
  endtask

  initial begin
    //                keys      rnd clr pls code  entry     cnt   down
    vecs[0]  = '{16'h0000, 1, 1'b0, 0, 4'h6, 16'h0006, 3'd1, 1'b1};
    vecs[1]  = '{16'h0040, 1, 1'b0, 0, 4'h6, 16'h0006, 3'd1, 1'b1};
    vecs[2]  = '{16'h0000, 2, 1'b0, 0, 4'h6, 16'h0006, 3'd1, 1'b0};
    vecs[3]  = '{16'h0200, 1, 1'b0, 0, 4'h6, 16'h0006, 3'd1, 1'b0};
    vecs[4]  = '{16'h0000, 1, 1'b0, 0, 4'h6, 16'h0006, 3'd1, 1'b0};
    vecs[5]  = '{16'h0200, 2, 1'b0, 1, 4'h9, 16'h0069, 3'd2, 1'b1};
    vecs[6]  = '{16'h0000, 2, 1'b0, 0, 4'h9, 16'h0069, 3'd2, 1'b0};
    vecs[7]  = '{16'h0000, 1, 1'b1, 0, 4'h9, 16'h0000, 3'd0, 1'b0};
    vecs[8]  = '{16'h0002, 2, 1'b0, 1, 4'h1, 16'h0001, 3'd1, 1'b1};
    vecs[9]  = '{16'h0000, 2, 1'b0, 0, 4'h1, 16'h0001, 3'd1, 1'b0};
    vecs[10] = '{16'h0004, 2, 1'b0, 1, 4'h2, 16'h0012, 3'd2, 1'b1};
    vecs[11] = '{16'h0000, 2, 1'b0, 0, 4'h2, 16'h0012, 3'd2, 1'b0};
    vecs[12] = '{16'h0008, 2, 1'b0, 1, 4'h3, 16'h0123, 3'd3, 1'b1};
    vecs[13] = '{16'h0000, 2, 1'b0, 0, 4'h3, 16'h0123, 3'd3, 1'b0};
    vecs[14] = '{16'h0010, 2, 1'b0, 1, 4'h4, 16'h1234, 3'd4, 1'b1};
    vecs[15] = '{16'h0000, 2, 1'b0, 0, 4'h4, 16'h1234, 3'd4, 1'b0};
    vecs[16] = '{16'h0020, 2, 1'b0, 1, 4'h5, 16'h2345, 3'd4, 1'b1};
    vecs[17] = '{16'h0000, 2, 1'b0, 0, 4'h5, 16'h2345, 3'd4, 1'b0};
    vecs[18] = '{16'h0000, 1, 1'b1, 0, 4'h5, 16'h0000, 3'd0, 1'b0};
    vecs[19] = '{16'h0021, 3, 1'b0, 0, 4'h5, 16'h0000, 3'd0, 1'b0};
    vecs[20] = '{16'h0001, 2, 1'b0, 1, 4'h0, 16'h0000, 3'd1, 1'b1};
    vecs[21] = '{16'h0000, 2, 1'b0, 0, 4'h0, 16'h0000, 3'd1, 1'b0};
    vecs[22] = '{16'h0400, 2, 1'b0, 1, 4'hA, 16'h000A, 3'd2, 1'b1};
    vecs[23] = '{16'h8000, 1, 1'b0, 0, 4'hA, 16'h000A, 3'd2, 1'b1};
    vecs[24] = '{16'h0000, 2, 1'b0, 0, 4'hA, 16'h000A, 3'd2, 1'b0};
    vecs[25] = '{16'h0011, 3, 1'b0, 0, 4'hA, 16'h000A, 3'd2, 1'b0};

    keys  = 16'h0000;
    clear = 1'b0;
    rst   = 1'b1;
    cyc   = 1;
    pulses = 0;
    first_pulse = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst col_n", 32'(col_n), 32'h0E);
    chk("rst key_code", 32'(key_code), 32'h0);
    chk("rst key_valid", 32'(key_valid), 32'h0);
    chk("rst entry", 32'(entry), 32'h0);
    chk("rst digit_count", 32'(digit_count), 32'h0);
    chk("rst key_down", 32'(key_down), 32'h0);

    // Idle scan: column walks every SCAN_DIV cycles, no events
    for (int i = 0; i < 2 * ROUND; i++) begin
      tick();
      if (((cyc - 1) % SCAN_DIV) == 2)
        chk($sformatf("scan col_n cyc%0d", cyc), 32'(col_n),
            32'(~(4'b0001 << (((cyc - 1) / SCAN_DIV) % 4)) & 4'hF));
    end
    chk("scan no key_valid", 32'(pulses), 32'd0);

    // Latency: key 6 held from a round start, pulse in cycle 33
    keys = 16'h0040;
    cyc = 1;
    pulses = 0;
    first_pulse = 0;
    for (int i = 0; i < DEBOUNCE * ROUND; i++) tick();
    chk("latency cycle", 32'(first_pulse), 32'd33);
    chk("latency pulses", 32'(pulses), 32'd1);
    chk("latency key_code", 32'(key_code), 32'h6);
    chk("latency entry", 32'(entry), 32'h0006);
    chk("latency digit_count", 32'(digit_count), 32'd1);
    chk("latency key_down", 32'(key_down), 32'd1);
    pulses = 0;
    for (int i = 0; i < 10 * ROUND; i++) tick();
    chk("hold no repeat", 32'(pulses), 32'd0);

    // Table of round-aligned vectors
    for (int v = 0; v < 26; v++) begin
      keys = vecs[v].keys;
      clear = vecs[v].clr;
      pulses = 0;
      for (int i = 0; i < vecs[v].rounds * ROUND; i++) begin
        tick();
        clear = 1'b0;
      end
      chk($sformatf("vec%0d pulses", v), 32'(pulses), 32'(vecs[v].pulses));
      chk($sformatf("vec%0d key_code", v), 32'(key_code), 32'(vecs[v].code));
      chk($sformatf("vec%0d entry", v), 32'(entry), 32'(vecs[v].ent));
      chk($sformatf("vec%0d digit_count", v), 32'(digit_count), 32'(vecs[v].cnt));
      chk($sformatf("vec%0d key_down", v), 32'(key_down), 32'(vecs[v].down));
    end

    // Reset in the middle of PRESS_DB with key 3 still held
    keys = 16'h0008;
    pulses = 0;
    for (int i = 0; i < ROUND + 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst pulses before", 32'(pulses), 32'd0);
    chk("midrst col_n", 32'(col_n), 32'h0E);
    chk("midrst key_down", 32'(key_down), 32'd0);
    chk("midrst entry", 32'(entry), 32'h0);
    chk("midrst key_code", 32'(key_code), 32'h0);
    cyc = 1;
    pulses = 0;
    first_pulse = 0;
    for (int i = 0; i < DEBOUNCE * ROUND; i++) tick();
    chk("midrst pulse cycle", 32'(first_pulse), 32'd33);
    chk("midrst pulses", 32'(pulses), 32'd1);
    chk("midrst key_code after", 32'(key_code), 32'h3);
    chk("midrst entry after", 32'(entry), 32'h0003);

    // clear in the same cycle as an accept
    keys = 16'h0000;
    for (int i = 0; i < DEBOUNCE * ROUND; i++) tick();
    chk("preclr key_down", 32'(key_down), 32'd0);
    keys = 16'h0080;
    pulses = 0;
    for (int i = 0; i < DEBOUNCE * ROUND - 1; i++) tick();
    chk("clracc no early pulse", 32'(pulses), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clracc key_valid", 32'(key_valid), 32'd1);
    chk("clracc key_code", 32'(key_code), 32'h7);
    chk("clracc entry", 32'(entry), 32'h0);
    chk("clracc digit_count", 32'(digit_count), 32'd0);
    tick();
    chk("clracc pulse ends", 32'(key_valid), 32'd0);
    chk("clracc key_down", 32'(key_down), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_entry.md
Name: keypad_scan_entry

Overview:
- Input-side counterpart to the board's multiplexed 4-digit seven-segment display driver.
- Scans a 4x4 hex matrix keypad by driving one active-low column at a time, reads the active-low rows, and debounces over whole scan rounds.
- Emits one key event per physical press and shifts each accepted hex digit into a 16-bit entry register; that register feeds one 16-bit field of the display's 64-bit number input.

Parameters:
SCAN_DIV, 16, clk cycles each column stays driven (dwell); must be >= 2
DEBOUNCE, 3, consecutive identical scan rounds needed to accept a press or a release; must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
row_n  input  4  keypad rows, active low, externally pulled up
clear  input  1  synchronous clear of entry and digit_count
col_n  output  4  column drive, one-cold: 1110, 1101, 1011, 0111
key_code  output  4  code of the last accepted key
key_valid  output  1  one-cycle pulse when a key is accepted
entry  output  16  shifted hex entry; newest digit in [3:0]
digit_count  output  3  digits entered so far, saturates at 4
key_down  output  1  high while in PRESSED or RELEASE_DB

Behaviour:
- Dwell counter div counts 0..SCAN_DIV-1. Column index col advances 0→1→2→3→0 on the cycle after div==SCAN_DIV-1. col_n = ~(1<<col).
- row_n is sampled only on the div==SCAN_DIV-1 cycle of each column, so the lines have settled for the full dwell.
- Key code = 4*row + col, where row is the active-low bit position in row_n and col is the column index.
- A scan round is complete when column 3 is sampled. The round result is one of:
  - ONE(code): exactly one key seen across all 4 columns.
  - NONE: zero keys seen, or two or more keys seen (ghosting or multi-press is treated as NONE).
- FSM, evaluated only on round-complete cycles:
  - IDLE: ONE(c) → PRESS_DB with cand=c, cnt=1. If DEBOUNCE==1, go straight to PRESSED and accept c.
  - PRESS_DB:
    - ONE(cand): cnt+1; when cnt reaches DEBOUNCE, go to PRESSED and accept cand.
    - ONE(other): cand=other, cnt=1.
    - NONE: go to IDLE.
  - PRESSED:
    - NONE → RELEASE_DB with cnt=1; if DEBOUNCE==1, go straight to IDLE.
    - ONE(any): stay. A held key never repeats, and a second key arriving while held is ignored.
  - RELEASE_DB:
    - NONE: cnt+1; when cnt reaches DEBOUNCE, go to IDLE.
    - ONE(any): go back to PRESSED, with no new event.
- Accept, in the cycle after the deciding round-complete cycle:
  - key_valid=1 for exactly one cycle.
  - key_code=code; held until the next accept.
  - entry <= {entry[11:0], code}.
  - digit_count <= min(digit_count+1, 4).
- Shifting continues past 4 digits; the oldest digit falls out of [15:12].
- clear=1: entry<=0, digit_count<=0.
  - clear in the same cycle as an accept: clear wins for entry and digit_count, but key_valid and key_code still update.
  - clear does not affect the FSM or the scan.
- Latency: a key stable from the start of a round produces key_valid 1 cycle after the end of the DEBOUNCE-th round, i.e. DEBOUNCE*4*SCAN_DIV + 1 cycles.
- Reset (synchronous, rst=1 at a clk edge):
  - Outputs: col_n=1110, key_code=0, key_valid=0, entry=0, digit_count=0, key_down=0.
  - Internal: div=0, col=0, state IDLE, cnt=0, round accumulators cleared.
  - A mid-round or mid-debounce reset discards the partial round. No key_valid follows reset even if a key is held; a held key must complete a full DEBOUNCE sequence after reset.
- Counter widths:
  - div: clog2(SCAN_DIV).
  - cnt: clog2(DEBOUNCE+1).
  - cnt never exceeds DEBOUNCE.

Test Plan:
- Reset and scan (SCAN_DIV=4, DEBOUNCE=2), no keys → col_n cycles 1110,1101,1011,0111 every 4 clks; key_valid never asserts; all outputs at reset values.
- Hold key row1/col2 (row_n=1101 while col_n=1011) from a round start → key_valid pulses once at cycle 33 with key_code=6, entry=0x0006, digit_count=1, key_down=1. Holding 10 more rounds → no further pulses.
- Bounce: key present for 1 round, absent 1 round, present 2 rounds → exactly one key_valid, and only after the 2 consecutive rounds. Release for 1 round then re-press → no new event. Release for 2 rounds → IDLE.
- Enter keys 1,2,3,4,5 (each pressed and released) → entry=0x2345, digit_count=4. Then clear → entry=0, digit_count=0.
- Two keys held together (codes 0 and 5) → no event. Release code 5, hold code 0 → after 2 rounds, key_valid with key_code=0.
- rst asserted during PRESS_DB with the key still held → no event at the old deadline. After rst drops, key_valid arrives 2 full rounds later. Separately, clear and an accept in the same cycle → key_valid=1, entry=0.
